dm_hs: RTL and testbench

Handshaked, parametrised data memory for the multicycle CPU. Replaces a raw word-indexed store with a request/done protocol and configurable wait states. Accepts byte addresses with an access size, and generates byte lanes internally. Checks alignment, and returns sign- or zero-extended load data, so the control FSM sequences memory states on `done` instead of fixed cycle counts.

---
 rtl/dm_hs.sv | 123 ++++++++++++
 tb/tb_dm_hs.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_hs.sv
// Handshaked 32-bit data memory: byte-addressed loads/stores with size and extension
// control, alignment checking and WAIT programmable wait states per access.
module dm_hs #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W+1:0] addr,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              wr_q, uns_q, err_q;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem [DEPTH];

    logic              commit, bad;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [31:0]       word_rd, wr_lanes, ld_val;
    logic [3:0]        be;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;

    assign word_idx = addr_q[ADDR_W+1:2];
    assign lane     = addr_q[1:0];
    assign commit   = (state == S_WAIT) && (cnt == 4'd0);
    assign bad      = (size_q == 2'b11) || (size_q == 2'b01 && lane[0]) ||
                      (size_q == 2'b10 && lane != 2'b00);
    assign word_rd  = mem[word_idx];

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign err  = done && err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane enables and lane-replicated store data; loads extract then extend.
    always_comb begin
        be       = 4'b0000;
        wr_lanes = wdata_q;
        ld_b     = word_rd[8*lane +: 8];
        ld_h     = lane[1] ? word_rd[31:16] : word_rd[15:0];
        ld_val   = word_rd;
        case (size_q)
            2'b00: begin
                be       = 4'b0001 << lane;
                wr_lanes = {4{wdata_q[7:0]}};
                ld_val   = uns_q ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
            end
            2'b01: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
                ld_val   = uns_q ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req) begin
                wr_q    <= wr;
                uns_q   <= uns;
                addr_q  <= addr;
                size_q  <= size;
                wdata_q <= wdata;
                cnt     <= 4'(WAIT);
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                err_q <= bad;
                if (bad)        rdata <= 32'd0;
                else if (!wr_q) rdata <= ld_val;
            end
        end
    end

    // NOTE: the storage array has no reset; contents stay undefined until written.
    always_ff @(posedge clk) begin
        if (commit && wr_q && !bad) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_dm_hs.sv
// Bench for dm_hs: three instances (WAIT=2, WAIT=3, ADDR_W=4/WAIT=0) checked against
// a byte-array reference model of the memory.
module tb_dm_hs;
    localparam int NW [3] = '{2, 3, 0};
    localparam int AMASK [3] = '{4095, 4095, 63};

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        req [3], wr [3], uns [3];
    logic [11:0] addr [3];
    logic [1:0]  size [3];
    logic [31:0] wdata [3], rdata [3];
    logic        busy [3], done [3], err [3];

    int tests_run = 0;
    int tests_failed = 0;

    bit [7:0]  mdl [3][4096];
    bit [31:0] mrd [3];

    always #5 clk = ~clk;

    dm_hs #(.ADDR_W(10), .WAIT(2)) u_w2 (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .wr(wr[0]), .addr(addr[0]),
        .size(size[0]), .uns(uns[0]), .wdata(wdata[0]), .busy(busy[0]),
        .done(done[0]), .err(err[0]), .rdata(rdata[0]));
    dm_hs #(.ADDR_W(10), .WAIT(3)) u_w3 (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .wr(wr[1]), .addr(addr[1]),
        .size(size[1]), .uns(uns[1]), .wdata(wdata[1]), .busy(busy[1]),
        .done(done[1]), .err(err[1]), .rdata(rdata[1]));
    dm_hs #(.ADDR_W(4), .WAIT(0)) u_w0 (
        .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .wr(wr[2]), .addr(addr[2][5:0]),
        .size(size[2]), .uns(uns[2]), .wdata(wdata[2]), .busy(busy[2]),
        .done(done[2]), .err(err[2]), .rdata(rdata[2]));

    // Reference: little-endian byte array; returns expected err and rdata.
    task automatic model(input int d, input bit w, input bit [11:0] a, input bit [1:0] sz,
                         input bit u, input bit [31:0] wd, output bit e, output bit [31:0] rd);
        int a0, n;
        bit [31:0] v;
        a0 = int'(a) & AMASK[d];
        e  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        n  = 1 << sz;
        if (e) begin
            mrd[d] = 32'd0;
        end else if (w) begin
            for (int k = 0; k < n; k++) mdl[d][a0 + k] = wd[8*k +: 8];
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = mdl[d][a0 + k];
            if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            mrd[d] = v;
        end
        rd = mrd[d];
    endtask

    task automatic drive(input int d, input bit r, input bit w, input bit [11:0] a,
                         input bit [1:0] sz, input bit u, input bit [31:0] wd);
        req[d] = r; wr[d] = w; addr[d] = a; size[d] = sz; uns[d] = u; wdata[d] = wd;
    endtask

    // One complete access; inputs are scrambled after acceptance to prove latching.
    task automatic run_op(input int d, input bit w, input bit [11:0] a, input bit [1:0] sz,
                          input bit u, input bit [31:0] wd, input string nm);
        bit e_exp;
        bit [31:0] rd_exp;
        int n;
        bit seen;
        model(d, w, a, sz, u, wd, e_exp, rd_exp);
        @(negedge clk);
        drive(d, 1'b1, w, a, sz, u, wd);
        @(posedge clk);
        #1 drive(d, 1'b0, 1'($urandom), 12'($urandom), 2'($urandom), 1'($urandom), $urandom);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (!busy[d]) begin
                tests_run++; tests_failed++;
                $display("FAIL %s busy: got 0 in cycle %0d, need 1", nm, n);
            end
            seen = done[d];
        end
        tests_run++;
        if (!seen || n != NW[d] + 2) begin
            tests_failed++;
            $display("FAIL %s latency: done in cycle %0d (seen=%0b), need %0d", nm, n, seen, NW[d] + 2);
        end
        tests_run++;
        if (err[d] !== e_exp || rdata[d] !== rd_exp) begin
            tests_failed++;
            $display("FAIL %s result: err=%0b rdata=%08h, need err=%0b rdata=%08h",
                     nm, err[d], rdata[d], e_exp, rd_exp);
        end
        @(negedge clk);
        tests_run++;
        if (done[d] !== 1'b0 || err[d] !== 1'b0 || busy[d] !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s after: done=%0b err=%0b busy=%0b, need 0/0/0", nm, done[d], err[d], busy[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (busy[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'd0) begin
                tests_failed++;
                $display("FAIL reset[%0d]: busy=%0b done=%0b err=%0b rdata=%08h, need 0", d,
                         busy[d], done[d], err[d], rdata[d]);
            end
        end
    endtask

    task automatic test_handshake();
        bit e;
        bit [31:0] rd;
        model(0, 1'b1, 12'h010, 2'b10, 1'b0, 32'h8899AABB, e, rd);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 12'h010, 2'b10, 1'b0, 32'h8899AABB);
        @(posedge clk);
        #1 drive(0, 1'b1, 1'b0, 12'h011, 2'b00, 1'b0, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (busy[0] !== (c <= 4) || done[0] !== (c == 4) || err[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL handshake cycle %0d: busy=%0b done=%0b err=%0b, need %0b/%0b/0",
                         c, busy[0], done[0], err[0], c <= 4, c == 4);
            end
        end
        model(0, 1'b0, 12'h011, 2'b00, 1'b0, 32'h0, e, rd);
        @(posedge clk);
        #1 req[0] = 1'b0;
        for (int c = 6; c <= 10; c++) begin
            @(negedge clk);
            tests_run++;
            if (busy[0] !== (c <= 9) || done[0] !== (c == 9)) begin
                tests_failed++;
                $display("FAIL held-req cycle %0d: busy=%0b done=%0b, need %0b/%0b",
                         c, busy[0], done[0], c <= 9, c == 9);
            end
            if (c == 9) begin
                tests_run++;
                if (rdata[0] !== 32'hFFFFFFAA || rd !== 32'hFFFFFFAA) begin
                    tests_failed++;
                    $display("FAIL held-req load: rdata=%08h, need FFFFFFAA", rdata[0]);
                end
            end
        end
    endtask

    task automatic test_load_ext();
        run_op(0, 1'b0, 12'h011, 2'b00, 1'b1, 32'h0, "lbu 0x11");
        run_op(0, 1'b0, 12'h012, 2'b01, 1'b0, 32'h0, "lh 0x12");
        run_op(0, 1'b0, 12'h010, 2'b10, 1'b1, 32'h0, "lw 0x10");
        tests_run++;
        if (rdata[0] !== 32'h8899AABB) begin
            tests_failed++;
            $display("FAIL lw 0x10 literal: rdata=%08h, need 8899AABB", rdata[0]);
        end
    endtask

    task automatic test_partial();
        run_op(0, 1'b1, 12'h012, 2'b01, 1'b0, 32'hFFFF1234, "sh 0x12");
        run_op(0, 1'b1, 12'h010, 2'b00, 1'b0, 32'hFFFFFF5C, "sb 0x10");
        run_op(0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, "lw partial");
        tests_run++;
        if (rdata[0] !== 32'h1234AA5C) begin
            tests_failed++;
            $display("FAIL partial literal: rdata=%08h, need 1234AA5C", rdata[0]);
        end
    endtask

    task automatic test_misalign();
        run_op(0, 1'b1, 12'h014, 2'b10, 1'b0, 32'h0BADF00D, "sw 0x14");
        run_op(0, 1'b0, 12'h013, 2'b01, 1'b0, 32'h0, "lh 0x13 misaligned");
        run_op(0, 1'b1, 12'h016, 2'b10, 1'b0, 32'hCAFEBABE, "sw 0x16 misaligned");
        run_op(0, 1'b1, 12'h014, 2'b11, 1'b0, 32'h11111111, "reserved size");
        run_op(0, 1'b0, 12'h014, 2'b10, 1'b0, 32'h0, "lw 0x14 unchanged");
    endtask

    task automatic test_reset_abort();
        bit seen_done;
        run_op(1, 1'b1, 12'h020, 2'b10, 1'b0, 32'h01234567, "pre-abort sw");
        run_op(1, 1'b0, 12'h020, 2'b10, 1'b0, 32'h0, "pre-abort lw");
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 12'h020, 2'b10, 1'b0, 32'hDEADBEEF);
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        tests_run++;
        if (busy[1] !== 1'b0 || done[1] !== 1'b0 || err[1] !== 1'b0 || rdata[1] !== 32'd0) begin
            tests_failed++;
            $display("FAIL abort outputs: busy=%0b done=%0b err=%0b rdata=%08h, need 0",
                     busy[1], done[1], err[1], rdata[1]);
        end
        #3 rst_n[1] = 1'b1;
        mrd[1] = 32'd0;
        seen_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen_done |= done[1];
        end
        tests_run++;
        if (seen_done) begin
            tests_failed++;
            $display("FAIL abort done: got done=1 after reset, need none");
        end
        run_op(1, 1'b0, 12'h020, 2'b10, 1'b0, 32'h0, "post-abort lw");
        tests_run++;
        if (rdata[1] !== 32'h01234567) begin
            tests_failed++;
            $display("FAIL post-abort literal: rdata=%08h, need 01234567", rdata[1]);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++)
            run_op(2, 1'b1, 12'(4 * i), 2'b10, 1'b0, $urandom, "w0 init");
        run_op(2, 1'b1, 12'h03C, 2'b10, 1'b0, 32'hA5A5F00F, "w0 sw idx15");
        run_op(2, 1'b0, 12'h03C, 2'b10, 1'b0, 32'h0, "w0 lw idx15");
        run_op(2, 1'b1, 12'h000, 2'b10, 1'b0, 32'h5A5A0FF0, "w0 sw idx0");
        run_op(2, 1'b0, 12'h03C, 2'b10, 1'b0, 32'h0, "w0 lw idx15 again");
        run_op(2, 1'b0, 12'h000, 2'b10, 1'b0, 32'h0, "w0 lw idx0");
        run_op(2, 1'b0, 12'h03F, 2'b00, 1'b0, 32'h0, "w0 lb top byte");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            run_op(0, 1'b1, 12'h100 + 12'(4 * i), 2'b10, 1'b0, $urandom, "rand init");
        for (int i = 0; i < 150; i++)
            run_op(0, 1'($urandom), 12'h100 + 12'($urandom_range(0, 63)),
                   2'($urandom), 1'($urandom), $urandom, "rand op");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            drive(d, 1'b0, 1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
            mrd[d] = 32'd0;
        end
        #23;
        test_reset();
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_handshake();
        test_load_ext();
        test_partial();
        test_misalign();
        test_reset_abort();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
